serial_collector: RTL
=====================

# serial_collector

Downstream stage of the `main` serializer: samples its serial bit `b`, bit index `s` and `active` strobe, reassembles 8-bit words LSB-first (bit `b` with index `s` lands in `dout[s]`) and queues completed words in a small FIFO read by a pop handshake. Detects index discontinuities, resynchronises on the next `s == 0`, and reports errors and overflow as single-cycle pulses.

## Interface
- `DEPTH`, default 4: FIFO depth in words. Must be a power of two and ≥ 2.
- `clk` input, 1 bit: clock. All state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `b` input, 1 bit: serial data bit from `main`.
- `s` input, 3 bits: index of `b` within the word, 0..7.
- `active` input, 1 bit: `b`/`s` valid this cycle.
- `rd` input, 1 bit: pop the head word. Ignored when empty.
- `dout` output, 8 bits: head-of-FIFO word. 0 when empty.
- `valid` output, 1 bit: FIFO non-empty.
- `full` output, 1 bit: FIFO holds `DEPTH` words.
- `count` output, log2(DEPTH)+1 bits: number of stored words.
- `err` output, 1 bit: 1-cycle pulse on an index discontinuity.
- `ovf` output, 1 bit: 1-cycle pulse when a completed word is dropped.

## Operation
- Assembly state: 8-bit shift/assembly register `acc`, 3-bit expected index `exp`, and a 2-state FSM.
- FSM states:
  - HUNT: after reset and after an error; waits for `s == 0`.
  - COLLECT: assembling a word.
- Sampling happens only on cycles with `active == 1`. With `active == 0`, all assembly state holds; a pause mid-word is legal and raises no error.
- HUNT, `active` and `s == 0`: `acc[0] <= b`, `exp <= 1`, go to COLLECT.
- HUNT, `active` and `s != 0`: ignore the bit. No `err` (the collector is not yet in sync).
- COLLECT, `active` and `s == exp`: `acc[s] <= b`, `exp <= exp + 1`.
- COLLECT, `s == exp == 7`: push `{b, acc[6:0]}` to the FIFO, set `exp <= 0`, stay in COLLECT. The next word must start at `s == 0`.
- COLLECT, `active` and `s != exp`:
  - Pulse `err` and discard the partial word.
  - If `s == 0`: restart with this bit (`acc[0] <= b`, `exp <= 1`, stay in COLLECT).
  - Otherwise go to HUNT.
- FIFO is a circular buffer with wr/rd pointers of log2(DEPTH) bits (natural wrap) and a separate `count`.
- Push while full, with no simultaneous pop: drop the word, pulse `ovf`, leave contents unchanged.
- Push and pop in the same cycle:
  - Not full: both happen and `count` is unchanged.
  - Full: the pop frees a slot, so the push succeeds, no `ovf`, `count` stays `DEPTH`.
- Pop while empty: no effect.
- `err` and `ovf` can pulse in the same cycle only if both conditions occur; they are independent.

## Timing
- Reset values:
  - `dout = 0`, `valid = 0`, `full = 0`, `count = 0`, `err = 0`, `ovf = 0`.
  - FSM = HUNT, `exp = 0`, `acc = 0`, pointers = 0, memory cleared.
- Reset asserted mid-word: the partial word is lost immediately and asynchronously. The first sample after release must be `s == 0`.
- Latency: the word completes on the edge that samples `s == 7`. `valid`, `dout` and `count` reflect it in the following cycle (1 clock).
- `dout` is a combinational read of the head entry. After a popping edge, it shows the next word or 0.
- `err` and `ovf` are registered: high for exactly the one cycle following the offending sampling edge.
- Throughput: one bit per active cycle, so at most one word per 8 cycles.

## Test plan
- Clean word: reset, then `active = 1` with `s = 0..7` on consecutive cycles and `b = 0,1,1,0,1,0,0,1`.
  - Required: one cycle after `s = 7`, `valid = 1`, `dout = 8'h96`, `count = 1`, `err = 0`.
  - Then `rd = 1` for one cycle: `valid = 0`, `dout = 0`.
- Pause: same word with `active = 0` for 3 cycles between `s = 3` and `s = 4`.
  - Required: `dout = 8'h96`, no `err`.
- Discontinuity: sequence `s = 0, 1, 2, 4`.
  - Required: `err` pulses once, no word is pushed, FSM is in HUNT.
  - Then a clean `s = 0..7` of `8'h1A`: required `dout = 8'h1A`, `count = 1`.
- Restart on zero: `s = 0, 1, 2, 0..7` carrying `8'h55`.
  - Required: one `err` pulse, then `dout = 8'h55` with no further errors.
- Overflow and ordering with `DEPTH = 4`:
  - Push words 1, 2, 3, 4: required `full = 1`, `count = 4`.
  - Fifth word with no `rd`: required `ovf` pulses and the word is dropped.
  - Sixth word completing with `rd = 1` on the same edge: required no `ovf`, `count = 4`.
  - Draining returns 2, 3, 4, 6 in order, with `count` reaching 0 and `valid = 0`.
- Reset mid-word: assert `rst` after `s = 4`.
  - Required: all outputs 0 immediately.
  - After release, a word starting at `s = 3` is ignored with no `err`; the next clean word is captured correctly.

Source files
------------

// File: rtl/serial_collector.sv
// serial_collector: reassembles LSB-first 8-bit words from an indexed serial
// stream and queues them in a small circular FIFO read by a pop handshake.
module serial_collector #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     b,
  input  logic [2:0]               s,
  input  logic                     active,
  input  logic                     rd,
  output logic [7:0]               dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t        state, state_nxt;
  logic [7:0]    acc, acc_nxt;
  logic [2:0]    exp, exp_nxt;
  logic          push_c;
  logic [7:0]    word_c;
  logic          err_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_pop_c, do_push_c;

  // Assembly state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      acc   <= 8'h00;
      exp   <= 3'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      exp   <= exp_nxt;
      err   <= err_nxt;
    end
  end

  // Next-state logic: sync hunting, bit placement, word completion, error detection
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    exp_nxt   = exp;
    push_c    = 1'b0;
    word_c    = 8'h00;
    err_nxt   = 1'b0;
    if (active) begin
      case (state)
        HUNT: begin
          if (s == 3'd0) begin
            acc_nxt[0] = b;
            exp_nxt    = 3'd1;
            state_nxt  = COLLECT;
          end
        end
        COLLECT: begin
          if (s == exp) begin
            acc_nxt[s] = b;
            exp_nxt    = exp + 3'd1;
            if (exp == 3'd7) begin
              push_c = 1'b1;
              word_c = {b, acc[6:0]};
            end
          end else begin
            err_nxt = 1'b1;
            if (s == 3'd0) begin
              acc_nxt[0] = b;
              exp_nxt    = 3'd1;
            end else begin
              exp_nxt   = 3'd0;
              state_nxt = HUNT;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // A pop frees a slot, so a push on a full FIFO succeeds when popped together
  always_comb begin
    do_pop_c  = rd && (count != CW'(0));
    do_push_c = push_c && (!full || do_pop_c);
  end

  // FIFO storage, pointers, occupancy and overflow pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= push_c && !do_push_c;
      if (do_push_c) begin
        mem[wr_ptr] <= word_c;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop_c) rd_ptr <= rd_ptr + AW'(1);
      if (do_push_c && !do_pop_c)      count <= count + CW'(1);
      else if (!do_push_c && do_pop_c) count <= count - CW'(1);
    end
  end

  // Status and head-of-queue view
  always_comb begin
    valid = (count != CW'(0));
    full  = (count == CW'(DEPTH));
    dout  = valid ? mem[rd_ptr] : 8'h00;
  end

endmodule
